// File: rtl/twisted_ring_counter_pkg.sv
// Purpose: shared mode/direction encodings and the reset-pattern helper for the counter.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package trc_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Widest counter supported by the reset-pattern helper.
  localparam int MAX_WIDTH = 64;

  // Start-of-sequence pattern for a mode. Callers size-cast the result
  // down to their own width:
  //   Johnson: all zeros.
  //   Ring:    one bit set at the LSB.
  function automatic logic [MAX_WIDTH-1:0] reset_pattern(input logic mode);
    logic [MAX_WIDTH-1:0] pat;
    pat = '0;
    if (mode == MODE_RING) pat[0] = 1'b1;
    return pat;
  endfunction

endpackage

// File: rtl/twisted_ring_counter_if.sv
// Purpose: control/status bundle of the twisted-ring counter (step, load, state, decode, wrap).
// Latency: n/a (wires only).
// Backpressure: none; the counter accepts a step or load on every cycle.
// Ports: en/mode/dir/load/load_val driven by the master; q/phase/illegal/wrap driven by the counter.
interface twisted_ring_counter_if #(
  parameter int WIDTH = 4
) ();
  localparam int PW = $clog2(2*WIDTH);

  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [PW-1:0]    phase;
  logic             illegal;
  logic             wrap;

  modport master (
    output en, mode, dir, load, load_val,
    input  q, phase, illegal, wrap
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output q, phase, illegal, wrap
  );
endinterface

// File: rtl/twisted_ring_counter_phase_decode.sv
// Purpose: decode a counter state into its sequence index and flag states illegal for the mode.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: q_i state, mode_i Johnson/ring select; phase_o index (0 when illegal), illegal_o.
module trc_phase_decode
  import trc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]             q_i,
  input  logic                         mode_i,
  output logic [$clog2(2*WIDTH)-1:0]   phase_o,
  output logic                         illegal_o
);
  localparam int PW = $clog2(2*WIDTH);

  int ones;
  int edges;
  int set_idx;

  always_comb begin
    ones    = 0;
    edges   = 0;
    set_idx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(q_i[i]);
      if (q_i[i]) set_idx = i;
    end
    // A legal Johnson state is a single run of ones against a single run
    // of zeros, i.e. at most one adjacent-bit transition.
    for (int i = 0; i < WIDTH-1; i++) begin
      if (q_i[i] != q_i[i+1]) edges = edges + 1;
    end

    phase_o   = '0;
    illegal_o = 1'b0;
    if (mode_i == MODE_RING) begin
      illegal_o = (ones != 1);
      if (!illegal_o) phase_o = PW'(set_idx);
    end else begin
      illegal_o = (edges > 1);
      if (!illegal_o) begin
        // Filling phase has ones growing from the LSB; draining phase has
        // zeros growing from the LSB and counts on from WIDTH.
        if (q_i[0])        phase_o = PW'(ones);
        else if (ones == 0) phase_o = '0;
        else               phase_o = PW'(2*WIDTH - ones);
      end
    end
  end

endmodule

// File: rtl/twisted_ring_counter.sv
// Purpose: parametrised Johnson/ring shift counter with load, self-correction, phase decode and wrap pulse.
// Latency: one cycle from en (or load) sampled high to the new q; wrap is registered alongside q.
// Backpressure: none; every enabled cycle advances, load beats en, reset beats both.
// Ports: clk, rst_n (synchronous, active-low); bus (slave) carries en/mode/dir/load/load_val in, q/phase/illegal/wrap out.
module twisted_ring_counter
  import trc_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int SELF_CORRECT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  twisted_ring_counter_if.slave bus
);
  localparam int            PW     = $clog2(2*WIDTH);
  localparam logic [PW-1:0] LAST_J = PW'(2*WIDTH - 1);
  localparam logic [PW-1:0] LAST_R = PW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] rst_pat;
  logic [WIDTH-1:0] shifted;
  logic [PW-1:0]    phase;
  logic             illegal;
  logic [PW-1:0]    last;

  trc_phase_decode #(.WIDTH(WIDTH)) u_decode (
    .q_i       (q_q),
    .mode_i    (bus.mode),
    .phase_o   (phase),
    .illegal_o (illegal)
  );

  assign rst_pat = WIDTH'(reset_pattern(bus.mode));
  assign last    = (bus.mode == MODE_RING) ? LAST_R : LAST_J;

  always_comb begin
    shifted = q_q;
    unique case ({bus.mode, bus.dir})
      {MODE_JOHNSON, DIR_FWD}: shifted = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_REV}: shifted = {~q_q[0], q_q[WIDTH-1:1]};
      {MODE_RING,    DIR_FWD}: shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      default:                 shifted = {q_q[0], q_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
    end else if (bus.en) begin
      if (illegal && (SELF_CORRECT != 0)) begin
        q_d = rst_pat;
      end else begin
        q_d = shifted;
        // A legal state always steps to a legal neighbour, so the current
        // phase alone tells us whether the next phase wraps. Illegal states
        // stay illegal under shifting and never wrap.
        wrap_d = !illegal &&
                 ((bus.dir == DIR_FWD) ? (phase == last) : (phase == '0));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= rst_pat;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.phase   = phase;
  assign bus.illegal = illegal;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_twisted_ring_counter.sv
module tb_twisted_ring_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  twisted_ring_counter_if #(.WIDTH(4)) bus ();
  twisted_ring_counter_if #(.WIDTH(4)) bus_nc ();

  twisted_ring_counter #(.WIDTH(4), .SELF_CORRECT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  twisted_ring_counter #(.WIDTH(4), .SELF_CORRECT(0)) dut_nc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mode = 1'b0; bus.en = 1'b0; bus.load = 1'b0;
    tick();
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL reset_q_johnson: got %b expected %b", bus.q, 4'b0000); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected %b", bus.wrap, 1'b0); end
    checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected %0d", bus.phase, 0); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected %b", bus.illegal, 1'b0); end
    checks++; if (bus_nc.q !== 4'b0000) begin errors++; $display("FAIL reset_q_nc: got %b expected %b", bus_nc.q, 4'b0000); end
  endtask

  task automatic test_johnson_fwd();
    logic [3:0] exp_q [9]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [2:0] exp_ph [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic       exp_w [9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    rst_n = 1'b1; bus.mode = 1'b0; bus.dir = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL jfwd_q[%0d]: got %b expected %b", i, bus.q, exp_q[i]); end
      checks++; if (bus.phase !== exp_ph[i]) begin errors++; $display("FAIL jfwd_phase[%0d]: got %0d expected %0d", i, bus.phase, exp_ph[i]); end
      checks++; if (bus.wrap !== exp_w[i]) begin errors++; $display("FAIL jfwd_wrap[%0d]: got %b expected %b", i, bus.wrap, exp_w[i]); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL jfwd_illegal[%0d]: got %b expected 0", i, bus.illegal); end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_ring_rev();
    logic [3:0] exp_q [5]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [2:0] exp_ph [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd3};
    // Leaving 0001 in reverse is a 0-to-last move, including the first step.
    logic       exp_w [5]  = '{1, 0, 0, 0, 1};
    rst_n = 1'b0; bus.mode = 1'b1; bus.en = 1'b1; bus.dir = 1'b1;
    tick();
    checks++; if (bus.q !== 4'b0001) begin errors++; $display("FAIL reset_q_ring: got %b expected %b", bus.q, 4'b0001); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL rrev_q[%0d]: got %b expected %b", i, bus.q, exp_q[i]); end
      checks++; if (bus.phase !== exp_ph[i]) begin errors++; $display("FAIL rrev_phase[%0d]: got %0d expected %0d", i, bus.phase, exp_ph[i]); end
      checks++; if (bus.wrap !== exp_w[i]) begin errors++; $display("FAIL rrev_wrap[%0d]: got %b expected %b", i, bus.wrap, exp_w[i]); end
    end
    bus.en = 1'b0; bus.dir = 1'b0;
  endtask

  task automatic test_illegal_load();
    bus.mode = 1'b0; bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'b0101;
    tick();
    checks++; if (bus.q !== 4'b0101) begin errors++; $display("FAIL ill_load_q: got %b expected %b", bus.q, 4'b0101); end
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b expected 1", bus.illegal); end
    checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL ill_phase: got %0d expected 0", bus.phase); end
    bus.load = 1'b0; bus.en = 1'b1;
    tick();
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL ill_correct_q: got %b expected %b", bus.q, 4'b0000); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL ill_correct_wrap: got %b expected 0", bus.wrap); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL ill_correct_flag: got %b expected 0", bus.illegal); end
    bus.en = 1'b0;
    // Same pattern without self-correction keeps shifting as an illegal state.
    bus_nc.load = 1'b1; bus_nc.load_val = 4'b0101;
    tick();
    bus_nc.load = 1'b0; bus_nc.en = 1'b1;
    tick();
    checks++; if (bus_nc.q !== 4'b1011) begin errors++; $display("FAIL nc_shift_q: got %b expected %b", bus_nc.q, 4'b1011); end
    checks++; if (bus_nc.illegal !== 1'b1) begin errors++; $display("FAIL nc_illegal: got %b expected 1", bus_nc.illegal); end
    checks++; if (bus_nc.wrap !== 1'b0) begin errors++; $display("FAIL nc_wrap: got %b expected 0", bus_nc.wrap); end
    bus_nc.en = 1'b0;
  endtask

  task automatic test_hold();
    rst_n = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.en = 1'b0; bus.load = 1'b0;
    tick();
    rst_n = 1'b1; bus.en = 1'b1;
    repeat (3) tick();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.q !== 4'b0111) begin errors++; $display("FAIL hold_q[%0d]: got %b expected %b", i, bus.q, 4'b0111); end
      checks++; if (bus.phase !== 3'd3) begin errors++; $display("FAIL hold_phase[%0d]: got %0d expected 3", i, bus.phase); end
      checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %b expected 0", i, bus.wrap); end
    end
    bus.load = 1'b1; bus.load_val = 4'b1100;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.q !== 4'b1100) begin errors++; $display("FAIL hold_load_q: got %b expected %b", bus.q, 4'b1100); end
    checks++; if (bus.phase !== 3'd6) begin errors++; $display("FAIL hold_load_phase: got %0d expected 6", bus.phase); end
  endtask

  task automatic test_load_priority();
    // load and en together: load wins, no shift of the loaded value.
    bus.mode = 1'b0; bus.dir = 1'b0; bus.load = 1'b1; bus.en = 1'b1; bus.load_val = 4'b1000;
    tick();
    checks++; if (bus.q !== 4'b1000) begin errors++; $display("FAIL load_pri_q: got %b expected %b", bus.q, 4'b1000); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL load_pri_wrap: got %b expected 0", bus.wrap); end
    bus.load = 1'b0; bus.en = 1'b0;
  endtask

  task automatic test_reset_override();
    bus.mode = 1'b0; bus.dir = 1'b0; bus.load = 1'b1; bus.load_val = 4'b1111; bus.en = 1'b0;
    tick();
    bus.load = 1'b0; bus.en = 1'b1;
    tick();
    checks++; if (bus.q !== 4'b1110) begin errors++; $display("FAIL rovr_setup_q: got %b expected %b", bus.q, 4'b1110); end
    rst_n = 1'b0; bus.load = 1'b1; bus.load_val = 4'b0101; bus.en = 1'b1;
    tick();
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL rovr_q: got %b expected %b", bus.q, 4'b0000); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL rovr_wrap: got %b expected 0", bus.wrap); end
    rst_n = 1'b1; bus.load = 1'b0;
    tick();
    checks++; if (bus.q !== 4'b0001) begin errors++; $display("FAIL rovr_resume_q: got %b expected %b", bus.q, 4'b0001); end
    bus.en = 1'b0;
  endtask

  task automatic test_mode_switch();
    bus.mode = 1'b0; bus.load = 1'b1; bus.load_val = 4'b0011; bus.en = 1'b0;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL msw_johnson_legal: got %b expected 0", bus.illegal); end
    bus.mode = 1'b1;
    #1;
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL msw_illegal_now: got %b expected 1", bus.illegal); end
    checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL msw_phase_now: got %0d expected 0", bus.phase); end
    bus.en = 1'b1;
    tick();
    checks++; if (bus.q !== 4'b0001) begin errors++; $display("FAIL msw_q: got %b expected %b", bus.q, 4'b0001); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL msw_illegal_after: got %b expected 0", bus.illegal); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL msw_wrap: got %b expected 0", bus.wrap); end
    bus.en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.load = 1'b0; bus.load_val = 4'b0000;
    bus_nc.en = 1'b0; bus_nc.mode = 1'b0; bus_nc.dir = 1'b0; bus_nc.load = 1'b0; bus_nc.load_val = 4'b0000;
    #2;
    test_reset();
    test_johnson_fwd();
    test_ring_rev();
    test_illegal_load();
    test_hold();
    test_load_priority();
    test_reset_override();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
